// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction word at a
// time from instruction memory, holds it in the instruction register and
// offers it to decode. A taken-branch redirect replaces the PC and throws
// away any instruction that is held or still in flight.
//
// Handshakes:
//   imem_req/imem_ack: imem_req and imem_addr stay stable from the first
//     request cycle up to and including the cycle imem_ack is high; the
//     read data is taken in that same ack cycle. A request is never
//     withdrawn early except by reset.
//   instr_valid/instr_ready: the held word moves to decode on a rising edge
//     where instr_valid and instr_ready are both 1 and redirect is 0.
//     instr_valid never depends on instr_ready, and instr, opcode and
//     instr_pc stay frozen while the word waits.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // instruction memory read port
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  // decode side
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode,
  output logic [PC_WIDTH-1:0]    instr_pc,
  // branch redirect
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    pc,
  // FSM state for debug and checkers: 0 IDLE, 1 FETCH, 2 HOLD, 3 DRAIN
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_INC = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    instr_pc_q;
  logic                   capture;

  // Next-state, next-PC and capture decision; redirect takes priority in
  // every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_pc;
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // With ack the stale word is simply dropped and a new request
          // starts; without ack the old request must still be finished.
          state_d = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          capture = 1'b1;
          pc_d    = pc_q + PC_INC;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (instr_ready) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The request address tracks the PC whenever a fresh request is about to
  // start and is otherwise held, which keeps the old address alive in DRAIN.
  always_comb begin
    addr_d = addr_q;
    if (state_d == FETCH) addr_d = pc_d;
  end

  // State, PC and request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Instruction register and its fetch address, loaded only on an
  // accepted (non-redirected) memory response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (capture) begin
      instr_q    <= imem_rdata;
      instr_pc_q <= pc_q;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr   = addr_q;
    instr_valid = (state_q == HOLD);
    instr       = instr_q;
    opcode      = instr_q[INSTR_WIDTH-1 -: 4];
    instr_pc    = instr_pc_q;
    pc          = pc_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory model with programmable latency
// answers requests and pushes {addr, data} of every word that should reach
// decode; a monitor pops and compares on each transfer.
module tb_instr_fetch_unit;

  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main DUT (RESET_PC = 0) ----------------
  logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc, pc;
  logic [3:0]  opcode;
  logic [1:0]  state_dbg;

  instr_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .state_dbg(state_dbg)
  );

  // ---------------- second DUT (RESET_PC = 0xFFFF) ----------------
  logic        req_h, ack_h, valid_h, ready_h, redir_h;
  logic [15:0] addr_h, rdata_h, instr_h, instr_pc_h, rpc_h, pc_h;
  logic [3:0]  opcode_h;
  logic [1:0]  state_h;

  instr_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_h), .imem_addr(addr_h),
    .imem_ack(ack_h), .imem_rdata(rdata_h),
    .instr_valid(valid_h), .instr_ready(ready_h),
    .instr(instr_h), .opcode(opcode_h), .instr_pc(instr_pc_h),
    .redirect(redir_h), .redirect_pc(rpc_h),
    .pc(pc_h), .state_dbg(state_h)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_xfer = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_lat   = 0;
  logic [15:0] mem_base  = 16'h1000;
  int          drop_acks = 0;

  // Answers mem_lat cycles after the request starts with mem_base+addr.
  initial begin
    int cnt;
    cnt        = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        cnt      = 0;
      end else begin
        if (imem_ack) cnt = 0;
        if (cnt == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_base + imem_addr;
          if (drop_acks > 0) drop_acks--;
          else exp_q.push_back({imem_addr, imem_rdata});
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end
    end
  end

  // Transfer monitor, sampled just before each rising edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && instr_valid && instr_ready && !redirect) begin
        n_xfer++;
        check_eq("sb_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("xfer", {instr_pc, instr}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ack_h       = 1'b0;
    ready_h     = 1'b0;
    drop_acks   = 0;
    step(2);
    exp_q.delete();
    check_eq("rst_req",   32'(imem_req),    32'd0);
    check_eq("rst_addr",  32'(imem_addr),   32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", 32'(instr),       32'h0);
    check_eq("rst_op",    32'(opcode),      32'h0);
    check_eq("rst_ipc",   32'(instr_pc),    32'h0);
    check_eq("rst_pc",    32'(pc),          32'h0);
    check_eq("rst_pc_hi", 32'(pc_h),        32'hFFFF);
    check_eq("rst_ad_hi", 32'(addr_h),      32'hFFFF);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!instr_valid && k < budget) begin
      step(1);
      k++;
    end
    check_eq("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int x0;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ack_h       = 1'b0;
    rdata_h     = '0;
    ready_h     = 1'b0;
    redir_h     = 1'b0;
    rpc_h       = '0;

    // Zero-wait streaming: one instruction every two cycles.
    mem_lat = 0; mem_base = 16'h1000;
    do_reset();
    instr_ready = 1'b1;
    x0 = n_xfer;
    step(1);
    check_eq("t1_req1",  32'(imem_req),  32'd1);
    check_eq("t1_addr1", 32'(imem_addr), 32'h0);
    step(1);
    check_eq("t1_valid", 32'(instr_valid), 32'd1);
    check_eq("t1_instr", 32'(instr),       32'h1000);
    check_eq("t1_op",    32'(opcode),      32'h1);
    step(1);
    check_eq("t1_vdrop", 32'(instr_valid), 32'd0);
    check_eq("t1_addr3", 32'(imem_addr),   32'h1);
    step(2);
    check_eq("t1_addr5", 32'(imem_addr),   32'h2);
    step(1);
    check_eq("t1_instr3", 32'(instr),      32'h1002);
    step(1);
    instr_ready = 1'b0;
    check_eq("t1_nxfer", 32'(n_xfer - x0), 32'd3);

    // Slow memory and stalled decode.
    mem_lat = 3; mem_base = 16'h8123;
    do_reset();
    x0 = n_xfer;
    step(2);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_req",  32'(imem_req),  32'd1);
      check_eq("t2_addr", 32'(imem_addr), 32'h0);
      step(1);
    end
    check_eq("t2_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_instr", 32'(instr),    32'h8123);
      check_eq("t2_op",    32'(opcode),   32'h8);
      check_eq("t2_ipc",   32'(instr_pc), 32'h0);
      check_eq("t2_pc",    32'(pc),       32'h1);
      check_eq("t2_hold",  32'(instr_valid), 32'd1);
      step(1);
    end
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    check_eq("t2_vdrop", 32'(instr_valid), 32'd0);
    check_eq("t2_nxfer", 32'(n_xfer - x0), 32'd1);

    // Redirect in HOLD beats a ready decode.
    mem_lat = 0; mem_base = 16'h1000;
    do_reset();
    x0 = n_xfer;
    step(2);
    check_eq("t3_hold", 32'(state_dbg), 32'(S_HOLD));
    void'(exp_q.pop_front());
    redirect = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b1;
    step(1);
    redirect = 1'b0; instr_ready = 1'b0;
    check_eq("t3_valid", 32'(instr_valid), 32'd0);
    check_eq("t3_addr",  32'(imem_addr),   32'h0040);
    check_eq("t3_pc",    32'(pc),          32'h0040);
    check_eq("t3_noxf",  32'(n_xfer - x0), 32'd0);
    step(1);
    check_eq("t3_instr", 32'(instr),    32'h1040);
    check_eq("t3_ipc",   32'(instr_pc), 32'h0040);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    check_eq("t3_nxfer", 32'(n_xfer - x0), 32'd1);

    // Redirect in FETCH before ack: DRAIN finishes the old request.
    mem_lat = 2; mem_base = 16'h1000;
    do_reset();
    x0 = n_xfer;
    step(1);
    redirect = 1'b1; redirect_pc = 16'h0020; drop_acks = 1;
    step(1);
    redirect = 1'b0;
    check_eq("t4_drain", 32'(state_dbg), 32'(S_DRAIN));
    check_eq("t4_addr0", 32'(imem_addr), 32'h0);
    check_eq("t4_req",   32'(imem_req),  32'd1);
    check_eq("t4_pc",    32'(pc),        32'h0020);
    step(1);
    check_eq("t4_addr1", 32'(imem_addr), 32'h0);
    step(1);
    check_eq("t4_fetch", 32'(state_dbg), 32'(S_FETCH));
    check_eq("t4_addr2", 32'(imem_addr), 32'h0020);
    check_eq("t4_noins", 32'(instr),     32'h0);
    check_eq("t4_nval",  32'(instr_valid), 32'd0);
    wait_valid(10);
    check_eq("t4_instr", 32'(instr),    32'h1020);
    check_eq("t4_ipc",   32'(instr_pc), 32'h0020);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    check_eq("t4_nxfer", 32'(n_xfer - x0), 32'd1);

    // PC wrap on the RESET_PC = 0xFFFF instance.
    mem_lat = 0;
    do_reset();
    step(1);
    check_eq("t5_req",  32'(req_h),  32'd1);
    check_eq("t5_addr", 32'(addr_h), 32'hFFFF);
    ack_h = 1'b1; rdata_h = 16'hABCD;
    step(1);
    ack_h = 1'b0;
    check_eq("t5_valid", 32'(valid_h),    32'd1);
    check_eq("t5_ipc",   32'(instr_pc_h), 32'hFFFF);
    check_eq("t5_pc",    32'(pc_h),       32'h0000);
    check_eq("t5_instr", 32'(instr_h),    32'hABCD);
    check_eq("t5_op",    32'(opcode_h),   32'hA);
    ready_h = 1'b1;
    step(1);
    ready_h = 1'b0;
    check_eq("t5_addr2", 32'(addr_h), 32'h0000);
    check_eq("t5_req2",  32'(req_h),  32'd1);

    // Asynchronous reset in the middle of an outstanding request.
    mem_lat = 0; mem_base = 16'h1000;
    do_reset();
    instr_ready = 1'b1;
    x0 = n_xfer;
    step(3);
    instr_ready = 1'b0; mem_lat = 5;
    check_eq("t6_pc1",  32'(pc),       32'h1);
    step(1);
    check_eq("t6_req",  32'(imem_req), 32'd1);
    check_eq("t6_nxfer", 32'(n_xfer - x0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rreq",  32'(imem_req),    32'd0);
    check_eq("t6_rval",  32'(instr_valid), 32'd0);
    check_eq("t6_rpc",   32'(pc),          32'h0);
    check_eq("t6_raddr", 32'(imem_addr),   32'h0);
    check_eq("t6_rins",  32'(instr),       32'h0);
    mem_lat = 0;
    do_reset();
    step(1);
    check_eq("t6_restart", 32'(imem_req),  32'd1);
    check_eq("t6_raddr2",  32'(imem_addr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
